// File: rtl/aes_pkg.sv
// aes_pkg
//   Shared definitions for the AES decryption datapath: state width in
//   columns, the inverse S-box, GF(2^8) arithmetic helpers and the FSM
//   state encoding used by aes_decrypt_core.
//   No ports (package).
package aes_pkg;

    // State width in 32-bit columns; AES fixes this at 4.
    localparam int Nb = 4;

    // FSM encoding, kept as plain constants so older tooling can read it.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_LAST  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Inverse S-box, entry 0 in the leftmost byte so INV_SBOX[b] is the lookup.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11b).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply; with a constant b this folds to a few XORs.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = xtime(sh);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round
//   One purely combinational AES decryption round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> (optional) InvMixColumns.
//   Ports:
//     state_in   [127:0] current state, byte 0 at [127:120], column-major
//     round_key  [127:0] round key for this round, same byte order
//     mix_en             1 = apply InvMixColumns (normal round), 0 = final round
//     state_out  [127:0] next state
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         mix_en,
    output logic [127:0] state_out
);

    logic [7:0] ark [16];
    logic [7:0] mc  [16];

    genvar gi;

    // Byte k sits in row k%4, column k/4. Row r is rotated right by r,
    // so output column c takes its row-r byte from input column c-r.
    for (gi = 0; gi < 16; gi++) begin : g_byte
        localparam int ROW = gi % 4;
        localparam int SRC = ((((gi / 4) - ROW) + Nb) % Nb) * 4 + ROW;
        assign ark[gi] = inv_sbox(state_in[127-8*SRC -: 8]) ^ round_key[127-8*gi -: 8];
        assign state_out[127-8*gi -: 8] = mix_en ? mc[gi] : ark[gi];
    end

    // InvMixColumns with the circulant {0e, 0b, 0d, 09}.
    for (gi = 0; gi < Nb; gi++) begin : g_col
        assign mc[4*gi+0] = gf_mul(ark[4*gi+0], 8'h0e) ^ gf_mul(ark[4*gi+1], 8'h0b)
                          ^ gf_mul(ark[4*gi+2], 8'h0d) ^ gf_mul(ark[4*gi+3], 8'h09);
        assign mc[4*gi+1] = gf_mul(ark[4*gi+0], 8'h09) ^ gf_mul(ark[4*gi+1], 8'h0e)
                          ^ gf_mul(ark[4*gi+2], 8'h0b) ^ gf_mul(ark[4*gi+3], 8'h0d);
        assign mc[4*gi+2] = gf_mul(ark[4*gi+0], 8'h0d) ^ gf_mul(ark[4*gi+1], 8'h09)
                          ^ gf_mul(ark[4*gi+2], 8'h0e) ^ gf_mul(ark[4*gi+3], 8'h0b);
        assign mc[4*gi+3] = gf_mul(ark[4*gi+0], 8'h0b) ^ gf_mul(ark[4*gi+1], 8'h0d)
                          ^ gf_mul(ark[4*gi+2], 8'h09) ^ gf_mul(ark[4*gi+3], 8'h0e);
    end

endmodule

// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core
//   Iterative AES-128/192/256 block decryptor, one round per clock.
//   Accepts a ciphertext in IDLE, runs Nr-1 full inverse rounds and one
//   final round, then holds the plaintext until the consumer takes it.
//   Ports:
//     clk, rst          clock; synchronous active-high reset
//     w        [1919:0] expanded key schedule, round key i at w[1919-128*i -: 128];
//                       must stay stable from acceptance until out_valid
//     in_valid/in_ready ciphertext handshake (in_ready only in IDLE)
//     in_data  [127:0]  ciphertext, byte 0 at [127:120]
//     out_valid/out_ready plaintext handshake (out_valid only in DONE)
//     out_data [127:0]  plaintext, same byte order
//     busy              high while rounds are being computed
module aes_decrypt_core
    import aes_pkg::*;
#(
    parameter int Nk = 8,
    parameter int Nr = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1919:0] w,
    input  logic          in_valid,
    input  logic [127:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [127:0]  out_data,
    input  logic          out_ready,
    output logic          busy
);

    logic [1:0]   fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;

    logic [127:0] rk_arr [16];
    logic [3:0]   rk_idx;
    logic [127:0] rk_sel;
    logic [127:0] round_out;

    genvar gi;

    // Slice the schedule into round keys; slots past the last round are tied off.
    for (gi = 0; gi < 16; gi++) begin : g_rk
        if (gi <= Nk + 6) begin : g_used
            assign rk_arr[gi] = w[1919-128*gi -: 128];
        end else begin : g_unused
            assign rk_arr[gi] = '0;
        end
    end

    // IDLE whitens with the last round key; every later state uses rk[rnd].
    assign rk_idx = (fsm_q == ST_IDLE) ? 4'(Nr) : rnd_q;
    assign rk_sel = rk_arr[rk_idx];

    aes_inv_round u_round (
        .state_in  (state_q),
        .round_key (rk_sel),
        .mix_en    (fsm_q == ST_ROUND),
        .state_out (round_out)
    );

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = in_data ^ rk_sel;
                    rnd_d   = 4'(Nr - 1);
                    fsm_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                state_d = round_out;
                if (rnd_q != 4'd0) begin
                    rnd_d = rnd_q - 4'd1;
                end
                if (rnd_q == 4'd1) begin
                    fsm_d = ST_LAST;
                end
            end
            ST_LAST: begin
                state_d = round_out;
                fsm_d   = ST_DONE;
            end
            ST_DONE: begin
                // Only the exit happens here; a new block waits for IDLE.
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            rnd_q   <= 4'd0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
        end
    end

    assign in_ready  = (fsm_q == ST_IDLE);
    assign out_valid = (fsm_q == ST_DONE);
    assign busy      = (fsm_q == ST_ROUND) || (fsm_q == ST_LAST);
    assign out_data  = state_q;

endmodule

// File: doc/aes_decrypt_core.md
AES_DECRYPT_CORE -- requirements
Module: aes_decrypt_core

Interface
REQ-001 Parameter: Nk, 8, key length in 32-bit words (4, 6 or 8).
REQ-002 Parameter: Nr, 14, round count; SHALL equal Nk+6, other values unsupported.
REQ-003 Parameter: Nb, 4, state width in 32-bit columns; fixed at 4.
REQ-004 clk  input  1  clock; all state changes on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 w  input  1920  expanded key schedule; round key i = w[1919-128*i -: 128]; unused low words zero for Nk=4/6.
REQ-007 in_valid  input  1  ciphertext offered.
REQ-008 in_data  input  128  ciphertext block, byte 0 at bits [127:120].
REQ-009 in_ready  output  1  block can accept ciphertext.
REQ-010 out_valid  output  1  plaintext available.
REQ-011 out_data  output  128  plaintext block, same byte order as in_data.
REQ-012 out_ready  input  1  consumer takes plaintext.
REQ-013 busy  output  1  high in ROUND or LAST.

Function
REQ-014 FSM states: IDLE, ROUND, LAST, DONE; transitions are REQ-015 to REQ-019 only.
REQ-015 IDLE: in_ready=1; on in_valid, state_reg <= in_data ^ rk[Nr], rnd <= Nr-1, go ROUND (acceptance edge E0).
REQ-016 ROUND: state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk[rnd]); rnd <= rnd-1; go LAST when rnd==1.
REQ-017 LAST: state_reg <= InvSubBytes(InvShiftRows(state_reg)) ^ rk[0]; go DONE.
REQ-018 Latency: out_valid first high in the cycle after edge E0+Nr (14 cycles for Nr=14, 12 for Nr=12, 10 for Nr=10).
REQ-019 DONE: out_valid=1, out_data=state_reg held stable; on out_ready go IDLE at that edge.
REQ-020 in_ready SHALL be 0 in ROUND, LAST and DONE; in_valid there is ignored and no data is lost or corrupted.
REQ-021 out_valid SHALL be 0 in all states except DONE; out_data is don't-care outside DONE.
REQ-022 w SHALL be held stable by the source from E0 until out_valid; the block does not latch w.
REQ-023 rnd is a 4-bit down-counter, never wraps below 0; rk index = rnd directly.
REQ-024 in_valid and out_ready both high in DONE: only the DONE->IDLE exit occurs; the new block is accepted no earlier than the next cycle.
REQ-025 Byte ops: InvShiftRows rotates row r right by r; InvMixColumns uses {0e,0b,0d,09} in GF(2^8), polynomial 0x11b.

Reset
REQ-026 rst high at a posedge: FSM <= IDLE, rnd <= 0, state_reg <= 0, out_valid=0, busy=0, in_ready=1 from the next cycle.
REQ-027 rst SHALL override every transition, including mid-ROUND and DONE; the in-flight block is discarded with no partial output.
REQ-028 rst has priority over simultaneous in_valid; that block is not accepted.

Structure
REQ-029 Shared package aes_pkg holds Nb, the inverse S-box table, the xtime/GF-multiply functions and the FSM state encoding.
REQ-030 One sub-module, aes_inv_round, SHALL be combinational: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns (select input for LAST).
REQ-031 The existing KeyExpansion/KeyExpansion192/KeyExpansion256 outputs feed w at top level; aes_decrypt_core instantiates no key expansion.

Verification
REQ-032 Nk=4, key 000102..0f, in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid 10 cycles after E0.
REQ-033 Nk=6, key 000102..17, in_data dda97ca4864cdfe06eaf70a0ec0d7191 -> same plaintext, 12 cycles.
REQ-034 Nk=8, key 000102..1f, in_data 8ea2b7ca516745bfeafc49904b496089 -> same plaintext, 14 cycles.
REQ-035 Nk=8, out_ready held low 20 cycles -> out_valid and out_data stable; in_valid pulses meanwhile ignored (in_ready=0).
REQ-036 Nk=8, rst asserted at cycle 7 after E0 -> next cycle IDLE, out_valid=0; the next block then decrypts correctly.
REQ-037 Back-to-back: three REQ-034 blocks with in_valid held high -> three correct outputs, one IDLE cycle between each.
